// File: rtl/uart_periph.sv
// UART peripheral: memory-mapped 8N1 transmitter and receiver with status flags
// and a level interrupt. TX and RX run independently on the same bit period.
`timescale 1ns/1ps
module uart_periph #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON  = 32'h4000_0020;
  // Counters hold 0..BAUD_DIV-1 and reload to 0, so 16 bits cover BAUD_DIV=65535.
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  // Bus decode
  logic sel_txd, sel_rxd, sel_con;
  logic tx_load, con_rd, rxd_rd, con_wr;
  logic unused_wdata;

  // TX datapath
  state_t      tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic [7:0]  txd_reg;
  logic        tx_busy, tx_end;

  // RX datapath
  state_t      rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_meta, rx_s, rx_arm;
  logic        rx_stop_smp, rx_good, rx_bad;

  // Status / control
  logic [7:0]  rx_data;
  logic        txie, rxie, txdone, rxrdy, ovr, fe;

  assign sel_txd = (addr == ADDR_TXD);
  assign sel_rxd = (addr == ADDR_RXD);
  assign sel_con = (addr == ADDR_CON);

  assign tx_busy = (tx_state != ST_IDLE);
  // A TXD write while a frame is in flight is dropped without side effects.
  assign tx_load = wr && sel_txd && !tx_busy;
  assign con_wr  = wr && sel_con;
  assign con_rd  = rd && sel_con;
  assign rxd_rd  = rd && sel_rxd;

  assign tx_end      = (tx_state == ST_STOP) && (tx_cnt == BIT_LAST);
  assign rx_stop_smp = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST);
  assign rx_good     = rx_stop_smp && rx_s;
  assign rx_bad      = rx_stop_smp && !rx_s;

  assign unused_wdata = ^wdata[31:8];

  assign irq = (txie & txdone) | (rxie & rxrdy);

  // TX FSM: serialises start, 8 data bits LSB first, and stop; tx is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_reg  <= '0;
      tx       <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      case (tx_state)
        ST_IDLE: begin
          tx     <= 1'b1;
          tx_cnt <= '0;
          if (tx_load) begin
            txd_reg  <= wdata[7:0];
            tx_shift <= wdata[7:0];
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          tx <= 1'b0;
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          tx <= tx_shift[0];
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= ST_STOP;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // RX synchroniser; resets low so a line held low through reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // RX FSM: arms on an idle-high line, starts on the following low, samples mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_arm   <= 1'b0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          rx_cnt <= '0;
          if (rx_s) begin
            rx_arm <= 1'b1;
          end else if (rx_arm) begin
            rx_arm   <= 1'b0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Status flags and enables; a set event in the same cycle as a clearing read wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data <= '0;
      rxrdy   <= 1'b0;
      ovr     <= 1'b0;
      fe      <= 1'b0;
      txdone  <= 1'b0;
      txie    <= 1'b0;
      rxie    <= 1'b0;
    end else begin
      if (rx_good) rx_data <= rx_shift;

      if (rx_good)               rxrdy <= 1'b1;
      else if (rxd_rd || con_rd) rxrdy <= 1'b0;

      if (rx_good && rxrdy) ovr <= 1'b1;
      else if (con_rd)      ovr <= 1'b0;

      if (rx_bad)      fe <= 1'b1;
      else if (con_rd) fe <= 1'b0;

      if (tx_end)                 txdone <= 1'b1;
      else if (tx_load || con_rd) txdone <= 1'b0;

      if (con_wr) begin
        txie <= wdata[0];
        rxie <= wdata[1];
      end
    end
  end

  // Read mux: zero unless a decoded address is being read.
  always_comb begin
    // NOTE: default assignment first keeps this purely combinational (no latch).
    rdata = '0;
    if (rd) begin
      if (sel_txd)      rdata = {24'b0, txd_reg};
      else if (sel_rxd) rdata = {24'b0, rx_data};
      else if (sel_con) rdata = {25'b0, fe, ovr, tx_busy, rxrdy, txdone, rxie, txie};
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph at BAUD_DIV=16: a tx line monitor checks
// frames against a queue of accepted TXD bytes; RX bytes are queued as driven.
`timescale 1ns/1ps
module tb_uart_periph;

  localparam int BD = 16;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rx = 1'b0;
  logic        tx, irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          tx_frames = 0;
  bit          mon_en  = 1'b1;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  last_rx = 8'h00;

  uart_periph #(.BAUD_DIV(BD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rx    (rx),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0; addr = '0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // Drives one 8N1 frame; only frames with a good stop bit are expected to land.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) rx_q.push_back(b);
    @(negedge clk);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Unread bytes are overwritten by later ones, so RXD shows the newest.
  function automatic logic [7:0] rx_expect();
    while (rx_q.size() > 0) last_rx = rx_q.pop_front();
    return last_rx;
  endfunction

  // tx line monitor: samples each bit at its middle and scores the frame.
  initial begin
    forever begin
      @(negedge tx);
      if (!reset && mon_en) begin
        logic [7:0] got;
        got = '0;
        repeat (BD / 2) @(posedge clk);
        #1 check("tx_start_bit", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(posedge clk);
          #1 got[i] = tx;
        end
        repeat (BD) @(posedge clk);
        #1 check("tx_stop_bit", {31'b0, tx}, 32'd1);
        tx_frames++;
        check("tx_frame_expected", {31'b0, tx_q.size() > 0}, 32'd1);
        if (tx_q.size() > 0) check("tx_frame_data", {24'b0, got}, {24'b0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [3];
    int t0;
    addrs[0] = A_TXD; addrs[1] = A_RXD; addrs[2] = A_CON;

    // Reset state, with rx held low through the release.
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      addr = addrs[i]; rd = 1'b1;
      #1 check("rst_rdata", rdata, 32'd0);
    end
    rd = 1'b0; addr = '0;
    @(negedge clk);
    reset = 1'b0;

    // A line already low at release must not start a frame.
    repeat (200) @(negedge clk);
    read_check("low_at_release_con", A_CON, 32'h0000_0000);
    rx = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 0xA5, TXIE=0; a TXD write while busy is ignored.
    tx_q.push_back(8'hA5);
    bus_write(A_TXD, 32'h0000_00A5);
    t0 = cyc;
    repeat (40) @(negedge clk);
    bus_write(A_TXD, 32'h0000_0011);
    read_check("txd_while_busy", A_TXD, 32'h0000_00A5);
    while (cyc < t0 + 158) @(negedge clk);
    read_check("con_busy_late", A_CON, 32'h0000_0010);
    check("irq_txie0", {31'b0, irq}, 32'd0);
    read_check("con_txdone", A_CON, 32'h0000_0004);
    read_check("con_cleared", A_CON, 32'h0000_0000);
    repeat (200) @(negedge clk);

    // Frame 0x5A with TXIE=1 raises irq until CON is read.
    bus_write(A_CON, 32'h0000_0001);
    tx_q.push_back(8'h5A);
    bus_write(A_TXD, 32'h0000_005A);
    t0 = cyc;
    while (cyc < t0 + 165) @(negedge clk);
    check("irq_txdone", {31'b0, irq}, 32'd1);
    read_check("con_txdone_ie", A_CON, 32'h0000_0005);
    check("irq_after_con", {31'b0, irq}, 32'd0);

    // RX 0x3C with RXIE=1.
    bus_write(A_CON, 32'h0000_0002);
    send_rx(8'h3C, 1'b1);
    check("irq_rxrdy", {31'b0, irq}, 32'd1);
    read_check("rxd_3c", A_RXD, {24'b0, rx_expect()});
    check("irq_after_rxd", {31'b0, irq}, 32'd0);
    read_check("con_after_rxd", A_CON, 32'h0000_0002);

    // Overrun: two bytes without an intervening read.
    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    read_check("con_ovr", A_CON, 32'h0000_002A);
    read_check("rxd_ovr", A_RXD, {24'b0, rx_expect()});
    read_check("con_ovr_cleared", A_CON, 32'h0000_0002);

    // 6-cycle glitch is a false start.
    @(negedge clk);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    read_check("con_glitch", A_CON, 32'h0000_0002);

    // Framing error leaves RXD unchanged.
    send_rx(8'h77, 1'b0);
    repeat (20) @(negedge clk);
    read_check("con_fe", A_CON, 32'h0000_0042);
    read_check("rxd_after_fe", A_RXD, {24'b0, rx_expect()});

    // Simultaneous TX and RX traffic.
    tx_q.push_back(8'h66);
    fork
      send_rx(8'h9C, 1'b1);
      bus_write(A_TXD, 32'h0000_0066);
    join
    repeat (20) @(negedge clk);
    check("irq_sim_rx", {31'b0, irq}, 32'd1);
    read_check("con_sim", A_CON, 32'h0000_000E);
    read_check("rxd_sim", A_RXD, {24'b0, rx_expect()});

    // Reset in the middle of a TX frame with irq pending.
    send_rx(8'h44, 1'b1);
    check("irq_before_rst", {31'b0, irq}, 32'd1);
    mon_en = 1'b0;
    bus_write(A_TXD, 32'h0000_0000);
    repeat (50) @(negedge clk);
    check("tx_midframe_low", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    addr = A_CON; rd = 1'b1;
    #1 check("midrst_con", rdata, 32'd0);
    rd = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    last_rx = 8'h00;
    mon_en = 1'b1;
    read_check("post_rst_con", A_CON, 32'h0000_0000);
    read_check("post_rst_txd", A_TXD, 32'h0000_0000);
    read_check("post_rst_rxd", A_RXD, {24'b0, rx_expect()});
    repeat (200) @(negedge clk);
    check("post_rst_tx_idle", {31'b0, tx}, 32'd1);

    // Exactly the three accepted frames were seen.
    check("tx_frame_count", tx_frames, 32'd3);
    check("tx_queue_empty", tx_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range 8..65535.
REQ-002 reset  input  1  asynchronous, active-high.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rd  input  1  bus read strobe, same timing as the timer/LED peripheral.
REQ-005 wr  input  1  bus write strobe.
REQ-006 addr  input  32  byte address; the block decodes only 0x40000018, 0x4000001C and 0x40000020.
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  combinational read data; 0 when rd=0 or addr is not decoded.
REQ-009 rx  input  1  serial receive line, asynchronous, idle high.
REQ-010 tx  output  1  serial transmit line, idle high.
REQ-011 irq  output  1  level interrupt request to the CPU.

Function
REQ-012 Register map:
- 0x40000018 TXD: write wdata[7:0] to start a transmission; reads return {24'b0, last byte loaded}.
- 0x4000001C RXD: read-only, {24'b0, rx_data}.
- 0x40000020 CON: bit0 TXIE (rw), bit1 RXIE (rw), bit2 TXDONE, bit3 RXRDY, bit4 TXBUSY, bit5 OVR, bit6 FE, bits 31:7 read 0.
- Writes to CON affect bits 1:0 only; other bits are read-only.
REQ-013 irq shall equal (TXIE & TXDONE) | (RXIE & RXRDY), computed combinationally from registered bits.
REQ-014 Frame format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); every bit lasts exactly BAUD_DIV clk cycles.
REQ-015 TX FSM states are IDLE, START, DATA, STOP.
- A write to TXD in IDLE loads the shift register and enters START; tx goes low on the first clk edge after the write edge.
- DATA shifts out 8 bits under a 3-bit bit counter; STOP drives 1 for BAUD_DIV cycles, then returns to IDLE.
REQ-016 TXBUSY shall be 1 in any TX state other than IDLE.
REQ-017 A write to TXD while TXBUSY=1 shall be ignored entirely: the byte is not stored and no flag changes.
REQ-018 TXDONE shall be set on the cycle STOP completes.
- It is cleared by a TXD write accepted in IDLE or by a CON read.
- If set and clear occur in the same cycle, set wins.
REQ-019 rx shall pass through a 2-flop synchronizer; all RX logic uses the synchronized value only.
REQ-020 RX FSM states are IDLE, START, DATA, STOP.
- IDLE→START on a synchronized 1→0 transition.
- START samples the line after BAUD_DIV/2 cycles (integer division); 1 = false start, return to IDLE; 0 enters DATA.
- DATA samples 8 bits at BAUD_DIV-cycle intervals, LSB first; then STOP samples once more after BAUD_DIV cycles.
REQ-021 Stop sample = 1:
- rx_data is updated and RXRDY is set.
- If RXRDY was already 1, OVR is set as well and rx_data is overwritten with the new byte.
REQ-022 Stop sample = 0: rx_data and RXRDY are unchanged, FE is set, and the FSM waits in IDLE until the line is 1 before accepting a new start.
REQ-023 An RXD read clears RXRDY; a CON read clears RXRDY, TXDONE, OVR and FE.
- Clears take effect at the clk edge where rd=1 and the addr matches.
- A new byte completing in that same cycle wins: the flag stays 1 and rx_data takes the new byte.
REQ-024 TX and RX operate fully independently; simultaneous TX and RX traffic is legal.
REQ-025 Bit-timing counters shall be wide enough for BAUD_DIV=65535 and shall reload exactly, with no cumulative drift across a frame.

Reset
REQ-026 While reset=1, and immediately on its assertion even mid-frame:
- tx=1 and irq=0.
- Both FSMs are in IDLE and all counters are 0.
- TXD, rx_data and CON are all 0, so rdata=0 for every address.
REQ-027 After reset deasserts, no frame resumes; a line already low at release shall not be taken as a start bit until it first returns to 1.

Verification (BAUD_DIV=16)
REQ-028 Write TXD=0xA5, then sample tx at the middle of each bit.
- Required: start bit, then bits 1,0,1,0,0,1,0,1, then stop bit; 160 cycles total.
- TXBUSY=1 throughout; TXDONE=1 afterwards.
- irq=1 only if TXIE=1.
REQ-029 Write TXD=0x11 while busy with 0xA5.
- Required: frame is still 0xA5; TXD reads 0xA5; no extra frame follows.
REQ-030 Drive an rx frame of 0x3C with correct timing.
- Required: RXRDY=1 and RXD reads 0x3C.
- With RXIE=1, irq=1; after one RXD read, RXRDY=0 and irq=0.
REQ-031 Send 0x01 then 0x02 with no intervening read.
- Required: RXD reads 0x02 with OVR=1 and RXRDY=1; one CON read clears both.
REQ-032 Drive rx low for 6 cycles only.
- Required: no RXRDY, no FE, and the FSM is back in IDLE.
- A frame with stop bit 0 gives FE=1 with RXD unchanged.
REQ-033 Assert reset in the middle of a TX frame.
- Required: tx=1 immediately, CON=0, and irq=0.
